// File: rtl/qs_fifo_pkg.sv
// Shared helpers for the qs_fifo family: width derivation and
// push/pop case encoding.
package qs_fifo_pkg;

    localparam logic [1:0] PUSH = 2'b10;
    localparam logic [1:0] POP  = 2'b01;
    localparam logic [1:0] BOTH = 2'b11;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int cnt_w(input int depth);
        return clog2(depth + 1);
    endfunction

    // Keep at least one bit so a depth-1 style corner never yields a zero-width bus.
    function automatic int ptr_w(input int depth);
        int w;
        w = clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/qs_fifo_ptr.sv
// Wrapping pointer for qs_fifo: counts 0..DEPTH-1 and wraps by compare,
// so any DEPTH works, not just powers of two.
module qs_fifo_ptr
    import qs_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_nxt;

    always_comb begin
        ptr_nxt = ptr;
        if (clr) begin
            ptr_nxt = '0;
        end else if (inc) begin
            ptr_nxt = (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/qs_fifo_lvl.sv
// Single-clock show-ahead FIFO with occupancy count and level flags.
// Define QS_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module qs_fifo_lvl
    import qs_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         push_data_i,
    input  logic                      pop_i,
    output logic [DATA_W-1:0]         pop_data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      almost_full_o,
    output logic                      almost_empty_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o
`ifdef QS_FIFO_ERR_EN
    ,
    input  logic                      err_clr_i,
    output logic                      overflow_o,
    output logic                      underflow_o
`endif
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = ptr_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              push_acc;
    logic              pop_acc;

    // A push into a full FIFO is only safe when a pop frees a slot the same edge.
    assign push_acc = push_i && (!full_o || pop_i) && !flush_i;
    assign pop_acc  = pop_i && !empty_o && !flush_i;

    qs_fifo_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush_i),
        .inc     (push_acc),
        .ptr     (wr_ptr)
    );

    qs_fifo_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush_i),
        .inc     (pop_acc),
        .ptr     (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    always_comb begin
        count_nxt = count;
        if (flush_i) begin
            count_nxt = '0;
        end else begin
            unique case ({push_acc, pop_acc})
                PUSH:    count_nxt = count + 1'b1;
                POP:     count_nxt = count - 1'b1;
                BOTH:    count_nxt = count;
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    assign count_o        = count;
    assign pop_data_o     = mem[rd_ptr];
    assign full_o         = (count == CNT_W'(DEPTH));
    assign empty_o        = (count == '0);
    assign almost_full_o  = (count >= CNT_W'(AF_THRESH));
    assign almost_empty_o = (count <= CNT_W'(AE_THRESH));

`ifdef QS_FIFO_ERR_EN
    logic ovf_set;
    logic unf_set;

    assign ovf_set = push_i && full_o && !pop_i && !flush_i;
    assign unf_set = pop_i && empty_o && !flush_i;

    // Clear beats a same-cycle set so software never loses an ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (err_clr_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            overflow_o  <= overflow_o | ovf_set;
            underflow_o <= underflow_o | unf_set;
        end
    end
`endif

endmodule

// File: tb/tb_qs_fifo_lvl.sv
// Directed bench for qs_fifo_lvl at DEPTH=5, AF=4, AE=1.
// Covers fill/drain, full/empty corners, wrap, flush and async reset.
module tb_qs_fifo_lvl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 5;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              reset_n;
    logic              flush_i;
    logic              push_i;
    logic [DATA_W-1:0] push_data_i;
    logic              pop_i;
    logic [DATA_W-1:0] pop_data_o;
    logic              full_o;
    logic              empty_o;
    logic              almost_full_o;
    logic              almost_empty_o;
    logic [CNT_W-1:0]  count_o;
    logic              err_clr;
    logic              ovf;
    logic              unf;

    int errors;
    int checks;

    qs_fifo_lvl #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (4),
        .AE_THRESH (1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush_i        (flush_i),
        .push_i         (push_i),
        .push_data_i    (push_data_i),
        .pop_i          (pop_i),
        .pop_data_o     (pop_data_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .count_o        (count_o)
`ifdef QS_FIFO_ERR_EN
        ,
        .err_clr_i      (err_clr),
        .overflow_o     (ovf),
        .underflow_o    (unf)
`endif
    );

`ifndef QS_FIFO_ERR_EN
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       flush;
        logic       push;
        logic       pop;
        logic       clr;
        logic [7:0] data;
        int         cnt;
        logic       emp;
        logic       ful;
        logic       af;
        logic       ae;
        logic       chk_d;
        logic [7:0] exp_d;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input int cnt, input logic emp,
                             input logic ful, input logic af, input logic ae);
        chk({tag, " count"}, int'(count_o), cnt);
        chk({tag, " empty"}, int'(empty_o), int'(emp));
        chk({tag, " full"}, int'(full_o), int'(ful));
        chk({tag, " afull"}, int'(almost_full_o), int'(af));
        chk({tag, " aempty"}, int'(almost_empty_o), int'(ae));
    endtask

    task automatic step(input logic fl, input logic pu, input logic po,
                        input logic cl, input logic [7:0] d);
        flush_i     = fl;
        push_i      = pu;
        pop_i       = po;
        err_clr     = cl;
        push_data_i = d;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        push_i  = 1'b0;
        pop_i   = 1'b0;
        err_clr = 1'b0;
    endtask

    function automatic vec_t mk(logic fl, logic pu, logic po, logic [7:0] d,
                                int c, logic cd, logic [7:0] ed,
                                logic eo, logic eu);
        vec_t v;
        v.flush = fl;
        v.push  = pu;
        v.pop   = po;
        v.clr   = 1'b0;
        v.data  = d;
        v.cnt   = c;
        v.emp   = (c == 0);
        v.ful   = (c == 5);
        v.af    = (c >= 4);
        v.ae    = (c <= 1);
        v.chk_d = cd;
        v.exp_d = ed;
        v.e_ovf = eo;
        v.e_unf = eu;
        return v;
    endfunction

    initial begin
        logic [7:0] d;
        errors      = 0;
        checks      = 0;
        reset_n     = 1'b0;
        flush_i     = 1'b0;
        push_i      = 1'b0;
        pop_i       = 1'b0;
        err_clr     = 1'b0;
        push_data_i = '0;

        tbl[0]  = mk(0, 1, 0, 8'h11, 1, 1, 8'h11, 0, 0);
        tbl[1]  = mk(0, 1, 0, 8'h12, 2, 1, 8'h11, 0, 0);
        tbl[2]  = mk(0, 1, 0, 8'h13, 3, 1, 8'h11, 0, 0);
        tbl[3]  = mk(0, 1, 0, 8'h14, 4, 1, 8'h11, 0, 0);
        tbl[4]  = mk(0, 1, 0, 8'h15, 5, 1, 8'h11, 0, 0);
        tbl[5]  = mk(0, 1, 0, 8'hAA, 5, 1, 8'h11, 1, 0);
        tbl[6]  = mk(0, 1, 1, 8'hBB, 5, 1, 8'h12, 1, 0);
        tbl[7]  = mk(0, 0, 1, 8'h00, 4, 1, 8'h13, 1, 0);
        tbl[8]  = mk(0, 0, 1, 8'h00, 3, 1, 8'h14, 1, 0);
        tbl[9]  = mk(0, 0, 1, 8'h00, 2, 1, 8'h15, 1, 0);
        tbl[10] = mk(0, 0, 1, 8'h00, 1, 1, 8'hBB, 1, 0);
        tbl[11] = mk(0, 0, 1, 8'h00, 0, 0, 8'h00, 1, 0);
        tbl[12] = mk(0, 0, 1, 8'h00, 0, 0, 8'h00, 1, 1);
        tbl[13] = mk(0, 1, 1, 8'h33, 1, 1, 8'h33, 1, 1);
        tbl[14] = mk(0, 0, 1, 8'h00, 0, 0, 8'h00, 1, 1);
        tbl[15] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        tbl[15].clr = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk_flags("reset", 0, 1, 0, 0, 1);
        chk("reset ovf", int'(ovf), 0);
        chk("reset unf", int'(unf), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].flush, tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].data);
            chk_flags($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].emp,
                      tbl[i].ful, tbl[i].af, tbl[i].ae);
            if (tbl[i].chk_d)
                chk($sformatf("vec%0d data", i), int'(pop_data_o), int'(tbl[i].exp_d));
`ifdef QS_FIFO_ERR_EN
            chk($sformatf("vec%0d ovf", i), int'(ovf), int'(tbl[i].e_ovf));
            chk($sformatf("vec%0d unf", i), int'(unf), int'(tbl[i].e_unf));
`endif
        end

        // Alternate push/pop across the 4->0 pointer wrap.
        d = 8'h40;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0, d);
            chk($sformatf("wrap%0d cnt1", i), int'(count_o), 1);
            chk($sformatf("wrap%0d data", i), int'(pop_data_o), int'(d));
            step(0, 0, 1, 0, 8'h00);
            chk($sformatf("wrap%0d cnt0", i), int'(count_o), 0);
            d = d + 8'h01;
        end

        // Flush with a concurrent push discards everything.
        step(0, 1, 0, 0, 8'h61);
        step(0, 1, 0, 0, 8'h62);
        step(0, 1, 0, 0, 8'h63);
        chk("pre-flush count", int'(count_o), 3);
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'hEE);
`ifdef QS_FIFO_ERR_EN
        chk("ovf before flush", int'(ovf), 1);
`endif
        step(1, 1, 0, 0, 8'h99);
        chk_flags("flush", 0, 1, 0, 0, 1);
`ifdef QS_FIFO_ERR_EN
        chk("ovf kept by flush", int'(ovf), 1);
        step(0, 0, 0, 1, 8'h00);
        chk("ovf cleared", int'(ovf), 0);
`endif
        step(0, 1, 0, 0, 8'h77);
        chk_flags("post-flush", 1, 0, 0, 0, 1);
        chk("post-flush data", int'(pop_data_o), 8'h77);
        step(0, 0, 1, 0, 8'h00);

        // Async reset mid-stream with four entries.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h80 + 8'(i));
        chk("pre-reset count", int'(count_o), 4);
        #2;
        reset_n = 1'b0;
        #1;
        chk_flags("async rst", 0, 1, 0, 0, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(0, 1, 0, 0, 8'h5A);
        chk("after rst data", int'(pop_data_o), 8'h5A);
        chk("after rst count", int'(count_o), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
